// File: rtl/sketch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sketch_pkg : shared types/constants for the hash-sketch stages.   Rev 1.0
// ---------------------------------------------------------------------------
package sketch_pkg;

    localparam int SK_NUM_CH = 3;
    localparam int SK_DATA_W = 4;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W = ch_width(SK_NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DECIDE  = 2'd2
    } state_t;

    // Result entry as seen by downstream sketch stages at default widths
    typedef struct packed {
        logic [SK_DATA_W-1:0] data;
        logic [CH_W-1:0]      ch;
        logic                 hit;
        logic                 timeout;
    } result_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : first-word-fall-through FIFO, pop-before-push when full. Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot the push lands in
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/hash_result_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hash_result_arbiter : aligns per-table results, picks one by priority. Rev 1.0
// ---------------------------------------------------------------------------
module hash_result_arbiter
    import sketch_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 4,
    parameter int MATCH_VAL  = 15,
    parameter int MODE       = 0,
    parameter int TIMEOUT    = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         Sys_clk,
    input  logic                         Rst,
    input  logic [NUM_CH*DATA_W-1:0]     Hash_rdata_i,
    input  logic [NUM_CH-1:0]            Hash_rdata_wr_i,
    output logic [DATA_W-1:0]            Mux_data_o,
    output logic [ch_width(NUM_CH)-1:0]  Mux_ch_o,
    output logic                         Mux_hit_o,
    output logic                         Mux_timeout_o,
    output logic                         Mux_valid_o,
    input  logic                         Mux_ready_i,
    output logic                         Busy_o,
    output logic [15:0]                  Drop_cnt_o
);

    localparam int          SEL_W   = ch_width(NUM_CH);
    localparam logic [7:0]  TMO_CNT = 8'(TIMEOUT);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  ch;
        logic              hit;
        logic              timeout;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    state_t                    state;
    logic [NUM_CH-1:0]         got;
    logic [NUM_CH*DATA_W-1:0]  cap;
    logic [7:0]                tcnt;
    logic                      to_flag;
    logic [15:0]               drop_cnt;

    logic [NUM_CH-1:0]         new_strb;
    logic [NUM_CH-1:0]         drop_mask;
    logic [NUM_CH-1:0]         got_nxt;
    logic [3:0]                drop_n;
    logic [16:0]               drop_sum;
    logic [15:0]               drop_nxt;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    entry_t                    sel_entry;
    entry_t                    head;

    // Lowest-index got channel meeting MODE wins; else highest-index got channel
    function automatic entry_t select_entry(
        input logic [NUM_CH-1:0]        g,
        input logic [NUM_CH*DATA_W-1:0] d,
        input logic                     tmo
    );
        entry_t            e;
        logic [DATA_W-1:0] v;
        logic              meets;
        e         = '0;
        e.timeout = tmo;
        for (int c = 0; c < NUM_CH; c++) begin
            if (g[c]) begin
                e.data = d[c*DATA_W +: DATA_W];
                e.ch   = SEL_W'(c);
            end
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            v     = d[c*DATA_W +: DATA_W];
            meets = (MODE == 0) ? (v == DATA_W'(MATCH_VAL)) : (v != DATA_W'(MATCH_VAL));
            if (g[c] && meets) begin
                e.data = v;
                e.ch   = SEL_W'(c);
                e.hit  = 1'b1;
            end
        end
        return e;
    endfunction

    always_comb begin
        new_strb  = '0;
        drop_mask = '0;
        case (state)
            ST_IDLE:    new_strb = Hash_rdata_wr_i;
            ST_COLLECT: begin
                new_strb  = Hash_rdata_wr_i & ~got;
                drop_mask = Hash_rdata_wr_i & got;
            end
            ST_DECIDE:  drop_mask = Hash_rdata_wr_i;
            default:    new_strb = '0;
        endcase
        got_nxt = got | new_strb;
        drop_n  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            drop_n = drop_n + {3'b000, drop_mask[c]};
        end
        drop_sum = {1'b0, drop_cnt} + {13'd0, drop_n};
        drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign sel_entry = select_entry(got, cap, to_flag);
    assign pop       = !fifo_empty && Mux_ready_i;
    assign push      = (state == ST_DECIDE) && (!fifo_full || pop);

    always_ff @(posedge Sys_clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            got      <= '0;
            cap      <= '0;
            tcnt     <= '0;
            to_flag  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_nxt;
            got      <= got_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                if (new_strb[c]) cap[c*DATA_W +: DATA_W] <= Hash_rdata_i[c*DATA_W +: DATA_W];
            end
            case (state)
                ST_IDLE: begin
                    if (|Hash_rdata_wr_i) begin
                        tcnt  <= 8'd1;
                        state <= (&Hash_rdata_wr_i) ? ST_DECIDE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (&got_nxt) begin
                        state <= ST_DECIDE;
                    end else if (tcnt == TMO_CNT) begin
                        state   <= ST_DECIDE;
                        to_flag <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                ST_DECIDE: begin
                    if (push) begin
                        got     <= '0;
                        tcnt    <= '0;
                        to_flag <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (Sys_clk),
        .rst     (Rst),
        .wr_en   (push),
        .wr_data (sel_entry),
        .rd_en   (Mux_ready_i),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign Mux_valid_o   = !fifo_empty;
    assign Mux_data_o    = Mux_valid_o ? head.data    : '0;
    assign Mux_ch_o      = Mux_valid_o ? head.ch      : '0;
    assign Mux_hit_o     = Mux_valid_o && head.hit;
    assign Mux_timeout_o = Mux_valid_o && head.timeout;
    assign Busy_o        = (state != ST_IDLE);
    assign Drop_cnt_o    = drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hash_result_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hash_result_arbiter : directed bench with lookup-level reference model.
// ---------------------------------------------------------------------------
module tb_hash_result_arbiter;

    localparam int NCH   = 3;
    localparam int DW    = 4;
    localparam int MV    = 15;
    localparam int TMO   = 15;
    localparam int DEPTH = 4;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic [NCH*DW-1:0] rdata = '0;
    logic [NCH-1:0]    wr    = '0;
    logic              ready = 1'b0;
    logic [DW-1:0]     d_o;
    logic [1:0]        ch_o;
    logic              hit_o;
    logic              tmo_o;
    logic              val_o;
    logic              busy_o;
    logic [15:0]       drop_o;

    always #4 clk = ~clk;

    hash_result_arbiter #(
        .NUM_CH     (NCH),
        .DATA_W     (DW),
        .MATCH_VAL  (MV),
        .MODE       (0),
        .TIMEOUT    (TMO),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Sys_clk         (clk),
        .Rst             (rst),
        .Hash_rdata_i    (rdata),
        .Hash_rdata_wr_i (wr),
        .Mux_data_o      (d_o),
        .Mux_ch_o        (ch_o),
        .Mux_hit_o       (hit_o),
        .Mux_timeout_o   (tmo_o),
        .Mux_valid_o     (val_o),
        .Mux_ready_i     (ready),
        .Busy_o          (busy_o),
        .Drop_cnt_o      (drop_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model: lookup lifecycle + output queue
    typedef struct {
        int data;
        int ch;
        bit hit;
        bit tmo;
    } exp_t;

    exp_t q[$];
    bit   open, closing, tmo_f, model_on;
    bit   have [NCH];
    int   val  [NCH];
    int   first, cyc, drops;

    function automatic bit all_have();
        for (int c = 0; c < NCH; c++) if (!have[c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t pick(input bit tm);
        exp_t e;
        e = '{data: 0, ch: 0, hit: 1'b0, tmo: tm};
        for (int c = 0; c < NCH; c++)
            if (have[c] && val[c] == MV) begin
                e.data = val[c]; e.ch = c; e.hit = 1'b1;
                return e;
            end
        for (int c = 0; c < NCH; c++)
            if (have[c]) begin e.data = val[c]; e.ch = c; end
        return e;
    endfunction

    task automatic model_step();
        bit   popd, pushing;
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
            open = 0; closing = 0; tmo_f = 0; drops = 0;
            for (int c = 0; c < NCH; c++) have[c] = 0;
            return;
        end
        popd    = (q.size() > 0) && ready;
        pushing = 1'b0;
        if (!open) begin
            if (wr != '0) begin
                open  = 1;
                first = cyc;
                for (int c = 0; c < NCH; c++)
                    if (wr[c]) begin have[c] = 1; val[c] = int'(rdata[c*DW +: DW]); end
                if (all_have()) closing = 1;
            end
        end else if (!closing) begin
            for (int c = 0; c < NCH; c++)
                if (wr[c]) begin
                    if (have[c]) drops++;
                    else begin have[c] = 1; val[c] = int'(rdata[c*DW +: DW]); end
                end
            if (all_have()) closing = 1;
            else if (cyc - first == TMO) begin closing = 1; tmo_f = 1; end
        end else begin
            for (int c = 0; c < NCH; c++) if (wr[c]) drops++;
            if (popd || q.size() < DEPTH) begin
                e = pick(tmo_f);
                pushing = 1'b1;
                open = 0; closing = 0; tmo_f = 0;
                for (int c = 0; c < NCH; c++) have[c] = 0;
            end
        end
        if (popd) void'(q.pop_front());
        if (pushing) q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            chk("m_busy", busy_o, open);
            chk("m_drop", drop_o, (drops > 65535) ? 65535 : drops);
            chk("m_valid", val_o, q.size() > 0);
            if (q.size() > 0) begin
                chk("m_data", d_o, q[0].data);
                chk("m_ch", ch_o, q[0].ch);
                chk("m_hit", hit_o, q[0].hit);
                chk("m_tmo", tmo_o, q[0].tmo);
            end else begin
                chk("m_idle_out", {d_o, ch_o, hit_o, tmo_o}, 0);
            end
        end
    end

    // ---------------- directed stimulus
    task automatic send(input logic [2:0] m, input int a, input int b, input int c);
        rdata = {4'(c), 4'(b), 4'(a)};
        wr    = m;
        @(negedge clk);
        wr    = '0;
    endtask

    task automatic pop_one();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int d, input int c, input int h, input int t);
        chk({tag, "_valid"}, val_o, 1);
        chk({tag, "_data"}, d_o, d);
        chk({tag, "_ch"}, ch_o, c);
        chk({tag, "_hit"}, hit_o, h);
        chk({tag, "_tmo"}, tmo_o, t);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        model_on = 1'b1;
        chk("rst_valid", val_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_drop", drop_o, 0);
        chk("rst_data", d_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // aligned match: legacy priority lands on ch1
        send(3'b111, 5, 15, 15);
        chk("t1_busy_decide", busy_o, 1);
        @(negedge clk);
        expect_out("t1", 15, 1, 1, 0);
        pop_one();

        // no channel matches: highest present channel, hit=0
        send(3'b111, 3, 7, 9);
        @(negedge clk);
        expect_out("t2", 9, 2, 0, 0);
        pop_one();

        // staggered arrival
        send(3'b100, 0, 0, 15);
        chk("t3_busy_n1", busy_o, 1);
        repeat (2) @(negedge clk);
        send(3'b001, 4, 0, 0);
        @(negedge clk);
        send(3'b010, 0, 6, 0);
        chk("t3_busy_decide", busy_o, 1);
        chk("t3_not_yet", val_o, 0);
        @(negedge clk);
        chk("t3_busy_done", busy_o, 0);
        expect_out("t3", 15, 2, 0 + 1, 0);
        pop_one();

        // timeout with ch2 missing
        send(3'b011, 2, 8, 0);
        repeat (14) @(negedge clk);
        chk("t4_busy", busy_o, 1);
        @(negedge clk);
        chk("t4_no_push_yet", val_o, 0);
        @(negedge clk);
        expect_out("t4", 8, 1, 0, 1);
        pop_one();

        // backpressure: four held, fifth stalls, sixth strobe set dropped
        for (int k = 0; k < 5; k++) begin
            send(3'b111, k, k, 10 + k);
            @(negedge clk);
        end
        send(3'b111, 1, 1, 1);
        chk("t5_drop", drop_o, 3);
        chk("t5_busy", busy_o, 1);
        expect_out("t5_head", 10, 2, 0, 0);
        repeat (3) @(negedge clk);
        chk("t5_stable", d_o, 10);
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t5_drain", d_o, 10 + k);
            @(negedge clk);
        end
        ready = 1'b0;
        chk("t5_empty", val_o, 0);
        chk("t5_idle", busy_o, 0);

        // reset during collection
        send(3'b001, 15, 0, 0);
        chk("t6_busy", busy_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", busy_o, 0);
        chk("t6_valid", val_o, 0);
        chk("t6_drop", drop_o, 0);
        repeat (20) @(negedge clk);
        chk("t6_no_output", val_o, 0);

        // duplicate strobe in COLLECT is dropped, first capture kept
        send(3'b001, 1, 0, 0);
        send(3'b001, 2, 0, 0);
        send(3'b110, 0, 15, 3);
        @(negedge clk);
        chk("t7_drop", drop_o, 1);
        expect_out("t7", 15, 1, 1, 0);
        pop_one();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hash_result_arbiter.md
Name: hash_result_arbiter

Overview:
- Parametrised successor to the fixed 3-way hash-result mux.
- Collects per-table lookup results that may arrive on different cycles, aligns them into one lookup, and selects one result by priority under a configurable match mode.
- Bounds waiting for missing tables with a timeout.
- Delivers the selected result through a valid/ready output FIFO toward the next sketch stage.

Parameters:
- NUM_CH, 3, number of hash tables/channels (2..8).
- DATA_W, 4, width of each result.
- MATCH_VAL, 15, sentinel code compared against each result.
- MODE, 0, 0 = select first channel equal to MATCH_VAL; 1 = select first channel not equal to MATCH_VAL.
- TIMEOUT, 15, cycles after first arrival before a partial lookup is forced (1..255).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- Sys_clk  in  1  system clock, 125 MHz.
- Rst  in  1  reset.
- Hash_rdata_i  in  NUM_CH*DATA_W  channel c result at bits [c*DATA_W +: DATA_W].
- Hash_rdata_wr_i  in  NUM_CH  per-channel result strobe, one-cycle pulse.
- Mux_data_o  out  DATA_W  selected result.
- Mux_ch_o  out  max(1,clog2(NUM_CH))  index of the selected channel.
- Mux_hit_o  out  1  1 = selection met the MODE condition; 0 = fallback.
- Mux_timeout_o  out  1  1 = lookup closed by timeout with missing channels.
- Mux_valid_o  out  1  output entry valid.
- Mux_ready_i  in  1  downstream accepts the entry when valid and ready are both high.
- Busy_o  out  1  a lookup is collecting or stalled.
- Drop_cnt_o  out  16  saturating count of dropped strobes.

Behaviour:
- Reset:
  - One clock, Sys_clk. Rst is synchronous and active-high.
  - Rst high clears state to IDLE, all got flags, capture registers, timeout counter, FIFO pointers and Drop_cnt_o.
  - All outputs read 0 in the cycle after Rst is sampled high.
  - Rst asserted mid-lookup discards that lookup and all FIFO contents. No output is produced for it.
- State machine:
  - IDLE: any strobe captures the data of each strobed channel and sets its got flag. Next state is COLLECT. If every channel is strobed in the same cycle, next state is DECIDE.
  - COLLECT: strobes on not-yet-got channels are captured. A strobe on an already-got channel is dropped and increments Drop_cnt_o. The timeout counter increments each cycle. When all got flags are set, next state is DECIDE. When the counter reaches TIMEOUT, next state is DECIDE with the timeout flag set.
  - DECIDE (one cycle): if the FIFO is not full, push {data, ch, hit, timeout}, clear the got flags and counter, and go to IDLE. If the FIFO is full, stay in DECIDE (stall).
  - Strobes arriving in DECIDE are dropped and counted, including the push cycle.
- Selection:
  - Considers only got channels.
  - Chooses the lowest-index got channel meeting the MODE condition, with hit = 1.
  - If none meets it, chooses the highest-index got channel, with hit = 0.
  - For NUM_CH = 3 and MODE = 0 with all channels present, this reproduces the legacy priority: channel 0, then 1, then 2.
- Latency:
  - All strobes sampled at edge N: push at edge N+1, Mux_valid_o high from edge N+2 when the FIFO was empty.
  - Timeout path: push occurs TIMEOUT+1 cycles after the first-arrival edge.
- FIFO:
  - First-word-fall-through.
  - Outputs hold stable while Mux_valid_o is high and Mux_ready_i is low.
  - Pop and push in the same cycle are allowed when the FIFO is full only if the pop is processed first.
  - Outputs are 0 when the FIFO is empty.
- Busy_o is high in COLLECT and DECIDE.
- Drop_cnt_o saturates at 16'hFFFF.

Decomposition:
- Shared package sketch_pkg holds:
  - the result-entry struct {data, ch, hit, timeout};
  - the state enum;
  - the clog2-derived CH_W constant.
- Sub-module sync_fifo: parametrised width/depth, FWFT, full/empty flags, synchronous active-high reset. It is reused by later sketch stages.
- Selection logic stays inline as a function.

Test Plan:
- Aligned lookup, MODE 0, NUM_CH 3: strobes all high at edge N with data {5,15,15} (ch0..2) -> at N+2 Mux_valid_o=1, Mux_data_o=15, Mux_ch_o=1, Mux_hit_o=1, Mux_timeout_o=0.
- No match: data {3,7,9} all strobed -> output data=9, ch=2, hit=0.
- Staggered arrival: ch2=15 at N, ch0=4 at N+3, ch1=6 at N+5 -> single push; output data=15, ch=2, hit=1, Busy_o high from N+1 through the push cycle.
- Timeout with TIMEOUT=15: only ch0=2 and ch1=8 arrive at N -> push at N+16; output data=8, ch=1, hit=0, timeout=1.
- Backpressure: hold Mux_ready_i=0 across 5 aligned lookups with FIFO_DEPTH=4 -> 4 entries held with stable outputs, 5th stalls in DECIDE, a 6th strobe set is dropped with Drop_cnt_o=3. Release ready -> entries drain in order.
- Reset mid-lookup: Rst high during COLLECT -> next cycle Busy_o=0, Mux_valid_o=0, Drop_cnt_o=0, and the partial lookup produces no output.
